step_accum: RTL and testbench

- Sits directly upstream of the `pwl` step-response table and consumes its output.
- Records the timestamps and polarities of the last `n_taps` transmitted edges.
- On each `start` it runs one sweep over that history:
  - drives `pwl_in` with each edge's elapsed time;
  - accepts `pwl_out` one cycle later;
  - adds rising-edge contributions and subtracts falling-edge contributions into one saturating sum.
- The result is the channel response to the edge history, presented on `out` with a single-cycle `out_valid`.

---
 rtl/step_accum.sv | 171 +++++++++++++++++
 tb/tb_step_accum.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/step_accum.sv
// Edge-history sweeper ahead of the pwl table: on start, feeds each recorded edge's elapsed time to pwl and
// sums the signed responses; result lands n_taps+2 cycles after start; start is ignored while busy.
module step_accum #(
  parameter int n_taps        = 8,
  parameter int time_width    = 32,
  parameter int in_width      = 16,
  parameter int pwl_out_width = 18,
  parameter int acc_width     = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [time_width-1:0]           time_now,
  input  logic                            edge_valid,
  input  logic                            edge_dir,
  input  logic                            start,
  output logic                            busy,
  output logic [in_width-1:0]             pwl_in,
  input  logic signed [pwl_out_width-1:0] pwl_out,
  output logic signed [acc_width-1:0]     out,
  output logic                            out_valid,
  output logic                            ovfl
);

  localparam int aw = $clog2(n_taps);
  localparam logic [aw-1:0] last_k = aw'(n_taps - 1);
  localparam logic [in_width-1:0] in_max = '1;
  localparam logic signed [acc_width-1:0] acc_max = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] acc_min = {1'b1, {(acc_width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [time_width-1:0] slot_time [n_taps];
  logic [n_taps-1:0]     slot_dir, slot_vld, vld_snap, vld_post;
  logic [aw-1:0]         wp, wp_snap, wp_post, k, rd_idx;
  logic [time_width-1:0] t_snap, pend_time, wr_time, rd_time, t_base, diff;
  logic                  pend_vld, pend_dir, wr_en, wr_dir, capture, drop;
  logic                  rd_dir, rd_vld, load_tap;
  logic [in_width-1:0]   rd_elapsed;
  logic                  tap_dir, tap_vld, acc_dir, acc_vld, acc_en;
  logic signed [acc_width-1:0] acc, acc_nxt;
  logic signed [acc_width:0]   acc_x, ext_x, sum;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (k == last_k) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Edges go straight into history in IDLE; while busy they wait in the pending slot until DONE.
  always_comb begin
    wr_en   = 1'b0;
    wr_time = time_now;
    wr_dir  = edge_dir;
    if (state == IDLE) begin
      wr_en = edge_valid;
    end else if (state == DONE) begin
      if (pend_vld) begin
        wr_en   = 1'b1;
        wr_time = pend_time;
        wr_dir  = pend_dir;
      end else begin
        wr_en = edge_valid;
      end
    end
    capture = edge_valid && (state == ISSUE || state == DRAIN) && !pend_vld;
    drop    = edge_valid && (state != IDLE) && pend_vld;
    wp_post  = wr_en ? wp + aw'(1) : wp;
    vld_post = slot_vld;
    if (wr_en) vld_post[wp] = 1'b1;
  end

  // Tap 0 is fetched at the start edge itself, so a simultaneous edge is bypassed in.
  always_comb begin
    rd_idx  = (state == IDLE) ? wp_post - aw'(1) : wp_snap - aw'(2) - k;
    rd_time = slot_time[rd_idx];
    rd_dir  = slot_dir[rd_idx];
    rd_vld  = (state == IDLE) ? vld_post[rd_idx] : vld_snap[rd_idx];
    if (state == IDLE && wr_en) begin
      rd_time = time_now;
      rd_dir  = edge_dir;
    end
    t_base = (state == IDLE) ? time_now : t_snap;
    diff   = t_base - rd_time;
    rd_elapsed = (diff > time_width'(in_max)) ? in_max : in_width'(diff);
    load_tap = (state == IDLE && start) || (state == ISSUE && k != last_k);
  end

  always_comb begin
    acc_x   = (acc_width+1)'(acc);
    ext_x   = (acc_width+1)'(pwl_out);
    sum     = acc_dir ? acc_x + ext_x : acc_x - ext_x;
    acc_nxt = acc;
    if (acc_vld) begin
      if (sum[acc_width] != sum[acc_width-1]) acc_nxt = sum[acc_width] ? acc_min : acc_max;
      else                                     acc_nxt = sum[acc_width-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) slot_time[wp] <= wr_time;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      wp        <= '0;
      wp_snap   <= '0;
      k         <= '0;
      slot_dir  <= '0;
      slot_vld  <= '0;
      vld_snap  <= '0;
      t_snap    <= '0;
      pend_vld  <= 1'b0;
      pend_dir  <= 1'b0;
      pend_time <= '0;
      pwl_in    <= '0;
      tap_dir   <= 1'b0;
      tap_vld   <= 1'b0;
      acc_dir   <= 1'b0;
      acc_vld   <= 1'b0;
      acc_en    <= 1'b0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      ovfl      <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (wr_en) begin
        slot_dir[wp] <= wr_dir;
        slot_vld[wp] <= 1'b1;
        wp           <= wp + aw'(1);
      end
      if (state == DONE) begin
        pend_vld <= 1'b0;
      end else if (capture) begin
        pend_vld  <= 1'b1;
        pend_time <= time_now;
        pend_dir  <= edge_dir;
      end
      if (drop) ovfl <= 1'b1;
      // Invalid slots present elapsed time 0 and contribute nothing.
      pwl_in  <= (load_tap && rd_vld) ? rd_elapsed : '0;
      tap_dir <= load_tap && rd_dir;
      tap_vld <= load_tap && rd_vld;
      acc_dir <= tap_dir;
      acc_vld <= tap_vld;
      acc_en  <= (state == ISSUE);
      if (state == IDLE && start) begin
        t_snap   <= time_now;
        wp_snap  <= wp_post;
        vld_snap <= vld_post;
        k        <= '0;
        acc      <= '0;
      end else if (state == ISSUE) begin
        k <= k + aw'(1);
      end
      if (acc_en) acc <= acc_nxt;
      out_valid <= (state == DRAIN);
      if (state == DRAIN) out <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_step_accum.sv
// Directed bench for step_accum: a delayed-identity pwl model feeds the main instance, a constant pwl feeds
// a narrow-accumulator instance used for saturation.
module tb_step_accum;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        time_now;
  logic               edge_valid, edge_dir, start;
  logic               busy, out_valid, ovfl;
  logic [15:0]        pwl_in;
  logic signed [17:0] pwl_out;
  logic signed [23:0] out;

  logic               busy2, out_valid2, ovfl2;
  logic [15:0]        pwl_in2;
  logic signed [17:0] pwl_out2;
  logic signed [17:0] out2;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0]        seq [8];
  int                 ov_cyc, busy_err;
  logic signed [23:0] ov_out;

  always #5 clk = ~clk;

  step_accum dut (
    .clk(clk), .rst(rst), .time_now(time_now), .edge_valid(edge_valid), .edge_dir(edge_dir),
    .start(start), .busy(busy), .pwl_in(pwl_in), .pwl_out(pwl_out), .out(out),
    .out_valid(out_valid), .ovfl(ovfl)
  );

  step_accum #(.acc_width(18)) dut_sat (
    .clk(clk), .rst(rst), .time_now(time_now), .edge_valid(edge_valid), .edge_dir(edge_dir),
    .start(start), .busy(busy2), .pwl_in(pwl_in2), .pwl_out(pwl_out2), .out(out2),
    .out_valid(out_valid2), .ovfl(ovfl2)
  );

  always_ff @(posedge clk) pwl_out <= {2'b00, pwl_in};
  assign pwl_out2 = 18'sd131071;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; start = 1'b0; edge_valid = 1'b0; edge_dir = 1'b0;
    tick; tick;
    rst = 1'b1;
  endtask

  task automatic push(input logic [31:0] t, input logic d);
    time_now = t; edge_valid = 1'b1; edge_dir = d;
    tick;
    edge_valid = 1'b0;
  endtask

  // Runs one sweep, recording pwl_in per issue cycle, the out_valid cycle and busy profile errors.
  task automatic sweep(input logic [31:0] t, input logic ev, input logic ed,
                       input int p1, input int p2, input logic [31:0] pt);
    time_now = t; start = 1'b1; edge_valid = ev; edge_dir = ed;
    tick;
    start = 1'b0; edge_valid = 1'b0;
    ov_cyc = -1; busy_err = 0; ov_out = '0;
    for (int c = 1; c <= 16; c++) begin
      if (c == p1 || c == p2) begin
        edge_valid = 1'b1; edge_dir = 1'b1; time_now = pt;
      end
      if (c <= 8) seq[c-1] = pwl_in;
      if (busy !== (c <= 10)) busy_err++;
      if (out_valid === 1'b1 && ov_cyc < 0) begin
        ov_cyc = c; ov_out = out;
      end
      tick;
      edge_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++; if (out !== 24'sd0)     begin n_err++; $display("FAIL reset_out got %0d want 0", out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (pwl_in !== 16'd0)   begin n_err++; $display("FAIL reset_pwl_in got %0d want 0", pwl_in); end
    n_cmp++; if (ovfl !== 1'b0)      begin n_err++; $display("FAIL reset_ovfl got %b want 0", ovfl); end
  endtask

  task automatic test_empty;
    do_reset;
    sweep(32'd500, 1'b0, 1'b0, -1, -1, 32'd0);
    n_cmp++; if (ov_cyc != 10)      begin n_err++; $display("FAIL empty_ov_cycle got %0d want 10", ov_cyc); end
    n_cmp++; if (ov_out !== 24'sd0) begin n_err++; $display("FAIL empty_out got %0d want 0", ov_out); end
    n_cmp++; if (busy_err != 0)     begin n_err++; $display("FAIL empty_busy bad_cycles %0d want 0", busy_err); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (seq[i] !== 16'd0) begin n_err++; $display("FAIL empty_pwl_in[%0d] got %0d want 0", i, seq[i]); end
    end
  endtask

  task automatic test_two_edges;
    logic [15:0] exp_seq [8];
    exp_seq = '{16'd50, 16'd100, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    do_reset;
    push(32'd100, 1'b1);
    push(32'd150, 1'b0);
    sweep(32'd200, 1'b0, 1'b0, -1, -1, 32'd0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (seq[i] !== exp_seq[i]) begin n_err++; $display("FAIL two_pwl_in[%0d] got %0d want %0d", i, seq[i], exp_seq[i]); end
    end
    n_cmp++; if (ov_out !== 24'sd50) begin n_err++; $display("FAIL two_out got %0d want 50", ov_out); end
    n_cmp++; if (out !== 24'sd50)    begin n_err++; $display("FAIL two_out_hold got %0d want 50", out); end
  endtask

  task automatic test_overwrite;
    do_reset;
    for (int i = 1; i <= 10; i++) push(32'(i * 10), 1'b1);
    sweep(32'd100, 1'b0, 1'b0, -1, -1, 32'd0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (seq[i] !== 16'(i * 10)) begin n_err++; $display("FAIL wrap_pwl_in[%0d] got %0d want %0d", i, seq[i], i * 10); end
    end
    n_cmp++; if (ov_out !== 24'sd280) begin n_err++; $display("FAIL wrap_out got %0d want 280", ov_out); end
  endtask

  task automatic test_in_sat;
    do_reset;
    push(32'd0, 1'b1);
    sweep(32'd70000, 1'b0, 1'b0, -1, -1, 32'd0);
    n_cmp++; if (seq[0] !== 16'd65535)  begin n_err++; $display("FAIL in_sat_pwl_in got %0d want 65535", seq[0]); end
    n_cmp++; if (ov_out !== 24'sd65535) begin n_err++; $display("FAIL in_sat_out got %0d want 65535", ov_out); end
  endtask

  task automatic test_time_wrap;
    do_reset;
    push(32'hFFFF_FFF0, 1'b1);
    sweep(32'h0000_0010, 1'b0, 1'b0, -1, -1, 32'd0);
    n_cmp++; if (seq[0] !== 16'd32) begin n_err++; $display("FAIL time_wrap_pwl_in got %0d want 32", seq[0]); end
    n_cmp++; if (seq[1] !== 16'd0)  begin n_err++; $display("FAIL time_wrap_pwl_in1 got %0d want 0", seq[1]); end
  endtask

  task automatic test_start_with_edge;
    do_reset;
    push(32'd250, 1'b0);
    sweep(32'd300, 1'b1, 1'b1, -1, -1, 32'd0);
    n_cmp++; if (seq[0] !== 16'd0)     begin n_err++; $display("FAIL start_edge_pwl_in0 got %0d want 0", seq[0]); end
    n_cmp++; if (seq[1] !== 16'd50)    begin n_err++; $display("FAIL start_edge_pwl_in1 got %0d want 50", seq[1]); end
    n_cmp++; if (ov_out !== -24'sd50)  begin n_err++; $display("FAIL start_edge_out got %0d want -50", ov_out); end
  endtask

  task automatic test_busy_edge;
    do_reset;
    push(32'd10, 1'b1);
    sweep(32'd20, 1'b0, 1'b0, 3, -1, 32'd15);
    n_cmp++; if (ov_out !== 24'sd10) begin n_err++; $display("FAIL busy_edge_out1 got %0d want 10", ov_out); end
    n_cmp++; if (ovfl !== 1'b0)      begin n_err++; $display("FAIL busy_edge_ovfl1 got %b want 0", ovfl); end
    sweep(32'd40, 1'b0, 1'b0, 3, 5, 32'd35);
    n_cmp++; if (seq[0] !== 16'd25)  begin n_err++; $display("FAIL busy_edge_pwl_in0 got %0d want 25", seq[0]); end
    n_cmp++; if (seq[1] !== 16'd30)  begin n_err++; $display("FAIL busy_edge_pwl_in1 got %0d want 30", seq[1]); end
    n_cmp++; if (ov_out !== 24'sd55) begin n_err++; $display("FAIL busy_edge_out2 got %0d want 55", ov_out); end
    n_cmp++; if (ovfl !== 1'b1)      begin n_err++; $display("FAIL busy_edge_ovfl2 got %b want 1", ovfl); end
  endtask

  task automatic test_reset_mid;
    int stray;
    do_reset;
    push(32'd0, 1'b1);
    sweep(32'd5, 1'b0, 1'b0, -1, -1, 32'd0);
    n_cmp++; if (ov_out !== 24'sd5) begin n_err++; $display("FAIL mid_pre_out got %0d want 5", ov_out); end
    time_now = 32'd10; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL mid_busy got %b want 0", busy); end
    n_cmp++; if (out !== 24'sd0) begin n_err++; $display("FAIL mid_out got %0d want 0", out); end
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid !== 1'b0) stray++;
      tick;
    end
    n_cmp++; if (stray != 0) begin n_err++; $display("FAIL mid_out_valid got %0d pulses want 0", stray); end
    sweep(32'd1000, 1'b0, 1'b0, -1, -1, 32'd0);
    n_cmp++; if (seq[0] !== 16'd0)  begin n_err++; $display("FAIL mid_pwl_in0 got %0d want 0", seq[0]); end
    n_cmp++; if (ov_cyc != 10)      begin n_err++; $display("FAIL mid_ov_cycle got %0d want 10", ov_cyc); end
    n_cmp++; if (ov_out !== 24'sd0) begin n_err++; $display("FAIL mid_empty_out got %0d want 0", ov_out); end
  endtask

  task automatic test_acc_sat;
    do_reset;
    for (int i = 1; i <= 8; i++) push(32'(i), 1'b1);
    sweep(32'd10, 1'b0, 1'b0, -1, -1, 32'd0);
    n_cmp++; if (ov_out !== 24'sd44)     begin n_err++; $display("FAIL sat_main_out got %0d want 44", ov_out); end
    n_cmp++; if (out2 !== 18'sd131071)   begin n_err++; $display("FAIL sat_out got %0d want 131071", out2); end
  endtask

  initial begin
    rst = 1'b0; time_now = '0; edge_valid = 1'b0; edge_dir = 1'b0; start = 1'b0;
    test_reset;
    test_empty;
    test_two_edges;
    test_overwrite;
    test_in_sat;
    test_time_wrap;
    test_start_with_edge;
    test_busy_edge;
    test_reset_mid;
    test_acc_sat;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
